// File: rtl/regfile_mp_if.sv
// regfile_mp_if -- bundle of the register-file control, read, write, issue and
// debug signals. Names carry the direction seen from the register file:
// i_* are driven by the master (core / bench), o_* by the register file.
//
//   i_clr_req    request a full re-clear of all registers
//   o_ready      file is in RUN and usable
//   i_ra/o_rd    NRD read ports (address IDXW, data XLEN per port)
//   o_rbusy      scoreboard busy bit for each read address
//   i_we/i_wa/i_wd  NWR write ports
//   i_iss_valid/i_iss_idx  issue: mark destination pending
//   i_dbg_ra/o_dbg_rd      debug read port, never bypassed
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  localparam int IDXW = $clog2(NREG);

  logic                  i_clr_req;
  logic                  o_ready;
  logic [NRD*IDXW-1:0]   i_ra;
  logic [NRD*XLEN-1:0]   o_rd;
  logic [NRD-1:0]        o_rbusy;
  logic [NWR-1:0]        i_we;
  logic [NWR*IDXW-1:0]   i_wa;
  logic [NWR*XLEN-1:0]   i_wd;
  logic                  i_iss_valid;
  logic [IDXW-1:0]       i_iss_idx;
  logic [IDXW-1:0]       i_dbg_ra;
  logic [XLEN-1:0]       o_dbg_rd;

  modport master (
    output i_clr_req, i_ra, i_we, i_wa, i_wd, i_iss_valid, i_iss_idx, i_dbg_ra,
    input  o_ready, o_rd, o_rbusy, o_dbg_rd
  );

  modport slave (
    input  i_clr_req, i_ra, i_we, i_wa, i_wd, i_iss_valid, i_iss_idx, i_dbg_ra,
    output o_ready, o_rd, o_rbusy, o_dbg_rd
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port register file with issue scoreboard and a
// self-clearing sequencer.
//
// Ports:
//   clk   single clock, all state on the rising edge
//   rstn  asynchronous active-low reset (state/scoreboard only, not storage)
//   bus   regfile_mp_if.slave (read/write/issue/debug ports, clr_req, ready)
//
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data
// (and a cleared busy bit) to the read ports. Without it, written data is
// visible one edge after the write.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_CLEAR | zeroing rf[1..NREG-1], one index per edge; ports gated to zero
// S_RUN   | normal operation, ready=1, writes/issues accepted
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input  logic         clk,
  input  logic         rstn,
  regfile_mp_if.slave  bus
);
  localparam int IDXW = $clog2(NREG);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREG - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [IDXW-1:0]   r_clr_cnt;
  logic              r_ready;
  logic [NREG-1:0]   r_busy;
  logic [XLEN-1:0]   r_rf [NREG];

  logic [NRD*XLEN-1:0] w_rd;
  logic [NRD-1:0]      w_rbusy;
  logic [XLEN-1:0]     w_dbg_rd;

  // Sequencer and scoreboard. Register 0 is hardwired, so its busy bit is
  // never set (a write to index 0 may "clear" it, which is a no-op).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= IDX_ONE;
      r_ready   <= 1'b0;
      r_busy    <= '0;
    end else if (r_state == S_CLEAR) begin
      if (bus.i_clr_req) begin
        r_clr_cnt <= IDX_ONE;
      end else if (r_clr_cnt == IDX_LAST) begin
        r_state   <= S_RUN;
        r_ready   <= 1'b1;
        r_clr_cnt <= IDX_ONE;
      end else begin
        r_clr_cnt <= r_clr_cnt + IDX_ONE;
      end
    end else begin
      if (bus.i_clr_req) begin
        r_state   <= S_CLEAR;
        r_ready   <= 1'b0;
        r_clr_cnt <= IDX_ONE;
        r_busy    <= '0;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.i_we[j]) begin
            r_busy[bus.i_wa[j*IDXW +: IDXW]] <= 1'b0;
          end
        end
        // Issue is applied after the write clears so that a same-cycle
        // issue and write-back of one index leaves it pending.
        if (bus.i_iss_valid && (bus.i_iss_idx != '0)) begin
          r_busy[bus.i_iss_idx] <= 1'b1;
        end
      end
    end
  end

  // Storage has no reset; it is zeroed only by the CLEAR walk. Later write
  // ports overwrite earlier ones, so the highest-index port wins a collision.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_rf[r_clr_cnt] <= '0;
    end else if (!bus.i_clr_req) begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.i_we[j] && (bus.i_wa[j*IDXW +: IDXW] != '0)) begin
          r_rf[bus.i_wa[j*IDXW +: IDXW]] <= bus.i_wd[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Read ports: gated to zero outside RUN and for index 0.
  always_comb begin
    w_rd    = '0;
    w_rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (r_ready && (bus.i_ra[i*IDXW +: IDXW] != '0)) begin
        w_rd[i*XLEN +: XLEN] = r_rf[bus.i_ra[i*IDXW +: IDXW]];
        w_rbusy[i]           = r_busy[bus.i_ra[i*IDXW +: IDXW]];
`ifdef RF_BYPASS_EN
        // A write discarded by a same-cycle clr_req is not forwarded.
        if (!bus.i_clr_req) begin
          for (int j = 0; j < NWR; j++) begin
            if (bus.i_we[j] && (bus.i_wa[j*IDXW +: IDXW] == bus.i_ra[i*IDXW +: IDXW])) begin
              w_rd[i*XLEN +: XLEN] = bus.i_wd[j*XLEN +: XLEN];
              w_rbusy[i]           = 1'b0;
            end
          end
        end
`endif
      end
    end
  end

  assign w_dbg_rd = (r_ready && (bus.i_dbg_ra != '0)) ? r_rf[bus.i_dbg_ra] : '0;

  assign bus.o_ready  = r_ready;
  assign bus.o_rd     = w_rd;
  assign bus.o_rbusy  = w_rbusy;
  assign bus.o_dbg_rd = w_dbg_rd;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- directed self-checking bench for regfile_mp
// (XLEN=32, NREG=32, NRD=2, NWR=2).
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int IDXW = 5;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_clr_req   = 1'b0;
    bus.i_we        = '0;
    bus.i_wa        = '0;
    bus.i_wd        = '0;
    bus.i_iss_valid = 1'b0;
    bus.i_iss_idx   = '0;
  endtask

  task automatic set_ra(input int p, input logic [IDXW-1:0] a);
    bus.i_ra[p*IDXW +: IDXW] = a;
  endtask

  task automatic wr(input int p, input logic [IDXW-1:0] a, input logic [31:0] d);
    bus.i_we[p]              = 1'b1;
    bus.i_wa[p*IDXW +: IDXW] = a;
    bus.i_wd[p*XLEN +: XLEN] = d;
  endtask

  task automatic issue(input logic [IDXW-1:0] a);
    bus.i_iss_valid = 1'b1;
    bus.i_iss_idx   = a;
  endtask

  function automatic logic [31:0] rd_of(input int p);
    return bus.o_rd[p*XLEN +: XLEN];
  endfunction

  // ready must stay low for 30 edges and rise on the 31st.
  task automatic clear_wait(input string tag);
    for (int k = 1; k <= 31; k++) begin
      tick();
      check($sformatf("%s_ready_e%0d", tag, k), {31'd0, bus.o_ready}, (k == 31) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    idle();
    bus.i_ra     = '0;
    bus.i_dbg_ra = '0;

    // Reset state
    #3;
    check("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    check("rst_rbusy", {30'd0, bus.o_rbusy}, 32'd0);
    check("rst_rd0", rd_of(0), 32'd0);
    check("rst_dbg", bus.o_dbg_rd, 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    clear_wait("por");

    // All registers cleared
    for (int i = 1; i < 32; i++) begin
      set_ra(0, 5'(i));
      set_ra(1, 5'((i % 31) + 1));
      #1;
      check($sformatf("por_x%0d_p0", i), rd_of(0), 32'd0);
      check($sformatf("por_x%0d_p1", i), rd_of(1), 32'd0);
    end

    // Write collision: highest port wins
    tick();
    wr(0, 5'd5, 32'h5555_0000);
    wr(1, 5'd5, 32'hAAAA_0001);
    set_ra(0, 5'd5);
    #1;
    check("coll_same_cycle", rd_of(0), BYP ? 32'hAAAA_0001 : 32'd0);
    tick();
    idle();
    #1;
    check("coll_next", rd_of(0), 32'hAAAA_0001);

    // Scoreboard
    set_ra(1, 5'd7);
    issue(5'd7);
    tick();
    idle();
    #1;
    check("busy7_set", {31'd0, bus.o_rbusy[1]}, 32'd1);
    set_ra(0, 5'd6);
    #1;
    check("busy6_clr", {31'd0, bus.o_rbusy[0]}, 32'd0);
    wr(0, 5'd7, 32'h0000_1234);
    tick();
    idle();
    #1;
    check("busy7_wclr", {31'd0, bus.o_rbusy[1]}, 32'd0);
    check("x7_1234", rd_of(1), 32'h0000_1234);
    issue(5'd7);
    wr(0, 5'd7, 32'h0000_5678);
    tick();
    idle();
    #1;
    check("busy7_setwins", {31'd0, bus.o_rbusy[1]}, 32'd1);
    check("x7_5678", rd_of(1), 32'h0000_5678);

    // Same-cycle read of a written register, debug port never bypassed
    wr(0, 5'd3, 32'h1111_1111);
    tick();
    idle();
    wr(0, 5'd3, 32'hDEAD_BEEF);
    set_ra(0, 5'd3);
    bus.i_dbg_ra = 5'd3;
    #1;
    check("x3_same_cycle", rd_of(0), BYP ? 32'hDEAD_BEEF : 32'h1111_1111);
    check("dbg_x3_old", bus.o_dbg_rd, 32'h1111_1111);
    tick();
    idle();
    #1;
    check("x3_next", rd_of(0), 32'hDEAD_BEEF);
    check("dbg_x3_new", bus.o_dbg_rd, 32'hDEAD_BEEF);

    // Two ports, different addresses
    wr(0, 5'd9, 32'h0000_0099);
    wr(1, 5'd10, 32'h0000_1010);
    tick();
    idle();
    set_ra(0, 5'd9);
    set_ra(1, 5'd10);
    #1;
    check("dual_x9", rd_of(0), 32'h0000_0099);
    check("dual_x10", rd_of(1), 32'h0000_1010);

    // Register 0 is hardwired
    wr(0, 5'd0, 32'hFFFF_FFFF);
    wr(1, 5'd0, 32'hFFFF_FFFF);
    issue(5'd0);
    tick();
    idle();
    set_ra(0, 5'd0);
    bus.i_dbg_ra = 5'd0;
    #1;
    check("x0_rd", rd_of(0), 32'd0);
    check("x0_busy", {31'd0, bus.o_rbusy[0]}, 32'd0);
    check("x0_dbg", bus.o_dbg_rd, 32'd0);

    // Fill x1..x31, then re-clear
    for (int i = 1; i < 32; i++) begin
      wr(0, 5'(i), 32'hC000_0000 | 32'(i));
      tick();
    end
    idle();
    issue(5'd12);
    tick();
    idle();
    set_ra(0, 5'd31);
    set_ra(1, 5'd12);
    bus.i_dbg_ra = 5'd20;
    #1;
    check("fill_x31", rd_of(0), 32'hC000_001F);
    check("fill_x12", rd_of(1), 32'hC000_000C);
    check("fill_busy12", {31'd0, bus.o_rbusy[1]}, 32'd1);
    check("fill_dbg20", bus.o_dbg_rd, 32'hC000_0014);
    bus.i_clr_req = 1'b1;
    wr(0, 5'd20, 32'hFFFF_FFFF);
    issue(5'd13);
    tick();
    idle();
    check("clr_ready0", {31'd0, bus.o_ready}, 32'd0);
    check("clr_rd_gated", rd_of(1), 32'd0);
    check("clr_busy_gated", {30'd0, bus.o_rbusy}, 32'd0);
    check("clr_dbg_gated", bus.o_dbg_rd, 32'd0);
    // Writes and issues during CLEAR must have no effect
    wr(0, 5'd5, 32'h0000_0BAD);
    wr(1, 5'd25, 32'h0000_0BAD);
    issue(5'd5);
    clear_wait("reclr");
    idle();
    for (int i = 1; i < 32; i++) begin
      set_ra(0, 5'(i));
      set_ra(1, 5'(i));
      #1;
      check($sformatf("reclr_x%0d", i), rd_of(0), 32'd0);
      check($sformatf("reclr_busy_x%0d", i), {30'd0, bus.o_rbusy}, 32'd0);
    end

    // clr_req during CLEAR restarts the walk
    wr(0, 5'd4, 32'h0000_0044);
    tick();
    idle();
    bus.i_clr_req = 1'b1;
    tick();
    bus.i_clr_req = 1'b0;
    set_ra(0, 5'd4);
    #1;
    check("restart_gated", rd_of(0), 32'd0);
    for (int k = 0; k < 5; k++) tick();
    bus.i_clr_req = 1'b1;
    tick();
    bus.i_clr_req = 1'b0;
    check("restart_ready0", {31'd0, bus.o_ready}, 32'd0);
    clear_wait("restart");
    check("restart_x4", rd_of(0), 32'd0);

    // Reset asserted mid-CLEAR at clr_cnt=10
    wr(0, 5'd2, 32'h0000_0022);
    tick();
    idle();
    bus.i_clr_req = 1'b1;
    tick();
    bus.i_clr_req = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    rstn = 1'b0;
    #1;
    check("midrst_ready", {31'd0, bus.o_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("midrst_hold%0d", k), {31'd0, bus.o_ready}, 32'd0);
    end
    rstn = 1'b1;
    clear_wait("midrst");
    set_ra(0, 5'd2);
    set_ra(1, 5'd31);
    #1;
    check("midrst_x2", rd_of(0), 32'd0);
    check("midrst_x31", rd_of(1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREG, default 32, register count; power of two, 4..64; IDXW = log2(NREG).
REQ-003 Parameter NRD, default 2, number of read ports, 1..4.
REQ-004 Parameter NWR, default 2, number of write ports, 1..2.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 clr_req  in  1  request full re-clear of all registers.
REQ-008 ready  out  1  high when the file is in RUN and usable.
REQ-009 ra  in  NRD*IDXW  read addresses, port i at bits [i*IDXW +: IDXW].
REQ-010 rd  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN], combinational.
REQ-011 rbusy  out  NRD  scoreboard busy bit of ra for port i, combinational.
REQ-012 we  in  NWR  write enable per write port.
REQ-013 wa  in  NWR*IDXW  write addresses.
REQ-014 wd  in  NWR*XLEN  write data.
REQ-015 iss_valid  in  1  issue: mark iss_idx pending.
REQ-016 iss_idx  in  IDXW  destination of issued instruction.
REQ-017 dbg_ra  in  IDXW  debug read address.
REQ-018 dbg_rd  out  XLEN  debug read data, combinational, never bypassed.

Function
REQ-019 States CLEAR and RUN; internal counter clr_cnt of IDXW bits.
REQ-020 CLEAR: each rising edge writes 0 to rf[clr_cnt], increments clr_cnt; at clr_cnt==NREG-1 that write completes and state goes to RUN.
REQ-021 CLEAR entered with clr_cnt=1; full clear takes exactly NREG-1 edges (31 for NREG=32).
REQ-022 ready = 1 only in RUN; ready is registered state, not decoded from inputs.
REQ-023 While ready=0: rd, rbusy, dbg_rd all 0; we and iss_valid ignored.
REQ-024 clr_req sampled high in RUN: next state CLEAR, clr_cnt=1, all busy bits cleared; writes in that same cycle are discarded.
REQ-025 clr_req high during CLEAR restarts clr_cnt at 1.
REQ-026 Register 0 reads 0 on every port always; writes and issues to index 0 ignored; busy[0] never set.
REQ-027 RUN write: for each port j with we[j] and wa[j]!=0, rf[wa[j]] <= wd[j] on rising edge.
REQ-028 Both write ports same nonzero address: port NWR-1 (highest index) wins.
REQ-029 Write to index k clears busy[k] on the same edge.
REQ-030 iss_valid with iss_idx!=0 sets busy[iss_idx]; set and write-clear of same index in one cycle: busy stays 1.
REQ-031 Reads of an address not written in the current cycle return rf contents; read latency 0, write visibility latency 1 edge (without bypass).

Reset
REQ-032 rstn low: state=CLEAR, clr_cnt=1, busy all 0, ready=0 immediately (asynchronous).
REQ-033 rf storage is not reset by rstn; it is zeroed only by CLEAR.
REQ-034 rstn asserted mid-CLEAR or mid-RUN: same as REQ-032; clear restarts from index 1 after release.

Configuration
REQ-035 Macro RF_BYPASS_EN defined: rd[i] for nonzero ra[i] matching an enabled write address in RUN returns that wd (highest matching port), and rbusy[i] returns 0 for that index.
REQ-036 RF_BYPASS_EN undefined: rd returns stored value and rbusy the stored busy bit; written data visible next cycle.

Verification
REQ-037 Release rstn, hold inputs idle -> ready=0 for 31 edges, ready=1 after 31st; rd of x1..x31 = 0.
REQ-038 RUN, we=2'b11, wa={5, 5}, wd={0xAAAA_0001 port1, 0x5555_0000 port0} -> next cycle rd of x5 = 0xAAAA_0001.
REQ-039 RUN, iss_valid idx 7 -> rbusy for x7 = 1; later we[0] wa=7 wd=0x1234 -> busy cleared, rd=0x1234; issue and write idx 7 same cycle -> busy remains 1.
REQ-040 Same-cycle we[0] wa=3 wd=0xDEAD_BEEF, ra port0=3 -> with RF_BYPASS_EN rd=0xDEAD_BEEF combinationally; without, old value, new value next cycle; dbg_rd old value in both.
REQ-041 After writes to x1..x31, pulse clr_req -> ready=0 next edge, busy all 0, 31 edges later ready=1 and all reads 0; writes during CLEAR have no effect.
REQ-042 Write/issue to x0 with wd=0xFFFF_FFFF -> rd of x0 = 0, rbusy=0; assert rstn low at clr_cnt=10 -> ready stays 0, full 31-edge clear after release.
